ps2_packet_receiver: RTL and testbench
======================================

PS2_PACKET_RECEIVER -- requirements
Module: ps2_packet_receiver

Interface
REQ-001 SHALL have parameter PKT_BYTES, default 3: bytes per packet, legal range 1..8.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 200000: maximum idle clk cycles between falling edges inside a packet (2 ms at 100 MHz).
REQ-003 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port ps2_clk, input, 1: asynchronous PS/2 clock from the device.
REQ-006 SHALL have port ps2_data, input, 1: asynchronous PS/2 data from the device.
REQ-007 SHALL have port pkt_data, output, 8*PKT_BYTES: last committed packet; first received byte in the MSBs.
REQ-008 SHALL have port pkt_valid, output, 1: pkt_data holds an unconsumed packet.
REQ-009 SHALL have port pkt_ready, input, 1: consumer accepts pkt_data when pkt_valid && pkt_ready.
REQ-010 SHALL have port frame_err, output, 1: one-cycle pulse on a start, parity or stop error.
REQ-011 SHALL have port overrun, output, 1: one-cycle pulse when a completed packet is dropped.
REQ-012 SHALL have port timeout, output, 1: one-cycle pulse on an inter-edge timeout; tied 0 when PS2_RX_TIMEOUT_EN is undefined.

Function
REQ-013 SHALL pass ps2_clk and ps2_data through a 2-FF synchroniser; a falling-edge strobe fires when the synchronised ps2_clk goes from 1 to 0 (3 clk cycles pin-to-strobe).
REQ-014 SHALL sample synchronised ps2_data only on the falling-edge strobe; 11 bits per frame, LSB-first: start(0), d0..d7, odd parity, stop(1).
REQ-015 SHALL implement FSM IDLE -> DATA -> CHECK -> IDLE:
- IDLE: a strobe with data=0 starts the frame; a strobe with data=1 is ignored.
- DATA: counts bits 1..10; after the stop-bit strobe it goes to CHECK.
- CHECK: lasts exactly one cycle.
REQ-016 In CHECK, SHALL declare the frame bad if the parity over d0..d7 plus the parity bit is even or stop=0; on a bad frame it SHALL pulse frame_err, discard all partial bytes of the packet and clear the byte counter to 0.
REQ-017 In CHECK, SHALL append a good byte to the packet shift register and increment the byte counter (width $clog2(PKT_BYTES), minimum 1); when the counter reaches PKT_BYTES-1 the packet SHALL complete and the counter SHALL wrap to 0.
REQ-018 On completion, if pkt_valid=0 or pkt_ready=1 in that cycle, SHALL load pkt_data and drive pkt_valid=1 on the following clk edge (one cycle after CHECK).
REQ-019 On completion with pkt_valid=1 and pkt_ready=0, SHALL keep the old pkt_data, drop the new packet and pulse overrun.
REQ-020 SHALL clear pkt_valid on pkt_valid && pkt_ready unless a new packet loads in the same cycle, in which case pkt_valid stays 1.
REQ-021 SHALL hold pkt_data stable while pkt_valid=1 and pkt_ready=0.

Reset
REQ-022 While reset_n=0 at a clk edge, the block SHALL return to IDLE with the bit counter, byte counter and timeout counter at 0.
REQ-023 While reset_n=0 at a clk edge, outputs SHALL be pkt_data=0, pkt_valid=0, frame_err=0, overrun=0, timeout=0.
REQ-024 While reset_n=0 at a clk edge, the synchroniser SHALL load 1s (line idle high).
REQ-025 A reset asserted mid-frame or mid-packet SHALL discard all partial data; the next start bit SHALL begin byte 0.

Configuration
REQ-026 With macro PS2_RX_TIMEOUT_EN defined, a counter SHALL clear on every strobe and increment in DATA, or in IDLE with byte counter != 0.
REQ-027 With PS2_RX_TIMEOUT_EN defined, when that counter reaches TIMEOUT_CYCLES the block SHALL pulse timeout, discard partial data, clear the counters and go to IDLE.
REQ-028 Without PS2_RX_TIMEOUT_EN, SHALL contain no timeout counter, SHALL tie timeout to 0 and SHALL never abandon a frame except on reset.

Structure
REQ-029 Shared package ps2_pkg SHALL hold the FSM state enum (IDLE, DATA, CHECK), FRAME_BITS=11, START_BIT=0 and STOP_BIT=1.
REQ-030 Sub-module ps2_sync_edge SHALL hold the synchroniser and falling-edge strobe; all else stays in ps2_packet_receiver.

Verification
REQ-031 Directed test: PKT_BYTES=3, good frames 0x08, 0x05, 0xFB, pkt_ready=1 -> pkt_valid one cycle after the third CHECK, pkt_data=0x0805FB, no error pulses.
REQ-032 Directed test: second byte sent with even parity -> frame_err pulses once, no pkt_valid, and the next three good bytes 0x09, 0x01, 0x02 yield 0x090102.
REQ-033 Directed test: pkt_ready=0, two full packets 0x080000 then 0x081111 -> overrun pulses once and pkt_data stays 0x080000; raising pkt_ready clears pkt_valid.
REQ-034 Directed test: pkt_ready pulsed in the same cycle as the next completion -> pkt_valid stays 1 and pkt_data updates to the new packet.
REQ-035 Directed test (PS2_RX_TIMEOUT_EN, TIMEOUT_CYCLES=1000): byte 0x08 then a 1000-cycle gap -> timeout pulses, and the next 3 bytes form a full packet starting at byte 0.
REQ-036 Directed test: reset_n=0 for one cycle after bit 5 of byte 2 -> all outputs 0, and a following 3-byte packet is received intact.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 packet receiver: FSM states, frame layout
// constants and the odd-parity helper.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        CHECK
    } state_e;

    localparam int   FRAME_BITS = 11;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;

    // True when data plus parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchroniser for the PS/2 clock and data lines plus a one-cycle
// strobe when the synchronised PS/2 clock falls.
module ps2_sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic fall_o,
    output logic data_o
);

    logic [2:0] clk_sync_q;
    logic [1:0] data_sync_q;

    // NOTE: non-blocking assignments make every stage take its neighbour's previous value, forming a true shift chain.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
        end else begin
            clk_sync_q  <= {clk_sync_q[1:0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
        end
    end

    assign fall_o = clk_sync_q[2] & ~clk_sync_q[1];
    assign data_o = data_sync_q[1];

endmodule

// File: rtl/ps2_packet_receiver.sv
// PS/2 receiver that assembles PKT_BYTES good frames into one packet with a
// valid/ready output. Define PS2_RX_TIMEOUT_EN to enable the inter-edge timeout.
module ps2_packet_receiver
    import ps2_pkg::*;
#(
    parameter int PKT_BYTES      = 3,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   ps2_clk,
    input  logic                   ps2_data,
    output logic [8*PKT_BYTES-1:0] pkt_data,
    output logic                   pkt_valid,
    input  logic                   pkt_ready,
    output logic                   frame_err,
    output logic                   overrun,
    output logic                   timeout
);

    localparam int PW  = 8 * PKT_BYTES;
    localparam int BCW = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;

    generate
        if (PKT_BYTES < 1 || PKT_BYTES > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
            $error("ps2_packet_receiver: PKT_BYTES must be 1..8 and TIMEOUT_CYCLES >= 1");
        end
    endgenerate

    logic fall;
    logic sdata;

    ps2_sync_edge u_sync (
        .clk        (clk),
        .reset_n    (reset_n),
        .ps2_clk_i  (ps2_clk),
        .ps2_data_i (ps2_data),
        .fall_o     (fall),
        .data_o     (sdata)
    );

    state_e          state_q;
    logic [3:0]      bit_cnt_q;
    logic [9:0]      frame_q;      // d0..d7, parity, stop once the frame is in
    logic [BCW-1:0]  byte_cnt_q;
    logic [PW-1:0]   pkt_sr_q;
    logic [PW-1:0]   pkt_data_q;
    logic            pkt_valid_q;
    logic            frame_err_q;
    logic            overrun_q;

    logic [PW-1:0]   pkt_next_d;
    logic            frame_good_d;
    logic            last_byte_d;

    assign pkt_next_d   = (pkt_sr_q << 8) | PW'(frame_q[7:0]);
    assign frame_good_d = odd_parity_ok(frame_q[7:0], frame_q[8]) && (frame_q[9] == STOP_BIT);
    assign last_byte_d  = (byte_cnt_q == BCW'(PKT_BYTES - 1));

`ifdef PS2_RX_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TCW-1:0] to_cnt_q;
    logic           timeout_q;
    logic           to_hit_d;

    assign to_hit_d = (to_cnt_q == TCW'(TIMEOUT_CYCLES));
    assign timeout  = timeout_q;
`else
    assign timeout  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            frame_q     <= '0;
            byte_cnt_q  <= '0;
            pkt_sr_q    <= '0;
            pkt_data_q  <= '0;
            pkt_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
            to_cnt_q    <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            if (pkt_valid_q && pkt_ready) begin
                pkt_valid_q <= 1'b0;
            end
`ifdef PS2_RX_TIMEOUT_EN
            timeout_q <= 1'b0;
            if (fall) begin
                to_cnt_q <= '0;
            end else if (state_q == DATA || (state_q == IDLE && byte_cnt_q != '0)) begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
`endif
            case (state_q)
                IDLE: begin
                    if (fall && sdata == START_BIT) begin
                        state_q   <= DATA;
                        bit_cnt_q <= 4'd1;
                    end
                end
                DATA: begin
                    if (fall) begin
                        frame_q <= {sdata, frame_q[9:1]};
                        if (bit_cnt_q == 4'(FRAME_BITS - 1)) begin
                            state_q   <= CHECK;
                            bit_cnt_q <= '0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                CHECK: begin
                    state_q <= IDLE;
                    if (!frame_good_d) begin
                        frame_err_q <= 1'b1;
                        byte_cnt_q  <= '0;
                        pkt_sr_q    <= '0;
                    end else if (last_byte_d) begin
                        byte_cnt_q <= '0;
                        pkt_sr_q   <= '0;
                        // A load wins over the handshake clear above, keeping pkt_valid high.
                        if (!pkt_valid_q || pkt_ready) begin
                            pkt_data_q  <= pkt_next_d;
                            pkt_valid_q <= 1'b1;
                        end else begin
                            overrun_q <= 1'b1;
                        end
                    end else begin
                        pkt_sr_q   <= pkt_next_d;
                        byte_cnt_q <= byte_cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
`ifdef PS2_RX_TIMEOUT_EN
            if (to_hit_d) begin
                timeout_q  <= 1'b1;
                state_q    <= IDLE;
                bit_cnt_q  <= '0;
                byte_cnt_q <= '0;
                pkt_sr_q   <= '0;
                to_cnt_q   <= '0;
            end
`endif
        end
    end

    assign pkt_data  = pkt_data_q;
    assign pkt_valid = pkt_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_ps2_packet_receiver.sv
// Self-checking bench: a packet-level reference model (queue of received bytes
// plus valid/ready rules) is compared against the DUT every cycle.
module tb_ps2_packet_receiver;

    localparam int PKT_BYTES = 3;
    localparam int TIMEOUT   = 1000;
    localparam int PW        = 8 * PKT_BYTES;

    logic          clk       = 1'b0;
    logic          reset_n   = 1'b0;
    logic          ps2_clk   = 1'b1;
    logic          ps2_data  = 1'b1;
    logic          pkt_ready = 1'b0;
    logic [PW-1:0] pkt_data;
    logic          pkt_valid;
    logic          frame_err;
    logic          overrun;
    logic          timeout;

    int checks = 0;
    int errors = 0;

    ps2_packet_receiver #(
        .PKT_BYTES      (PKT_BYTES),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .pkt_data  (pkt_data),
        .pkt_valid (pkt_valid),
        .pkt_ready (pkt_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a completed frame takes effect at the clk edge numbered `stamp`.
    typedef struct {
        int         stamp;
        bit         is_to;
        bit         good;
        logic [7:0] b;
    } ev_t;

    ev_t           evq[$];
    logic [7:0]    m_bytes[$];
    int            cyc        = 0;
    int            last_stamp = 0;
    logic [PW-1:0] m_data     = '0;
    bit            m_valid    = 0;
    bit            m_ferr     = 0;
    bit            m_ovr      = 0;
    bit            m_to       = 0;
    int            m_now;
    bit            m_vbefore;
    ev_t           m_ev;
    logic [PW-1:0] m_pkt;

    always @(posedge clk) begin
        m_now = cyc;
        cyc++;
        if (!reset_n) begin
            m_data = '0; m_valid = 0; m_ferr = 0; m_ovr = 0; m_to = 0;
            m_bytes.delete();
            evq.delete();
        end else begin
            m_vbefore = m_valid;
            m_ferr = 0; m_ovr = 0; m_to = 0;
            if (m_valid && pkt_ready) m_valid = 0;
            while (evq.size() > 0 && evq[0].stamp <= m_now) begin
                m_ev = evq.pop_front();
                if (m_ev.is_to) begin
                    m_to = 1;
                    m_bytes.delete();
                end else if (!m_ev.good) begin
                    m_ferr = 1;
                    m_bytes.delete();
                end else begin
                    m_bytes.push_back(m_ev.b);
                    if (m_bytes.size() == PKT_BYTES) begin
                        m_pkt = '0;
                        foreach (m_bytes[i]) m_pkt = (m_pkt << 8) | PW'(m_bytes[i]);
                        m_bytes.delete();
                        if (!m_vbefore || pkt_ready) begin
                            m_data  = m_pkt;
                            m_valid = 1;
                        end else begin
                            m_ovr = 1;
                        end
                    end
                end
            end
        end
    end

    // Compare process plus tallies of observed pulses and accepted packets.
    bit            cmp_en    = 0;
    int            ferr_seen = 0;
    int            ovr_seen  = 0;
    int            to_seen   = 0;
    int            acc_cnt   = 0;
    logic [PW-1:0] acc_last  = '0;

    always @(negedge clk) begin
        if (cmp_en) begin
            check("pkt_valid", pkt_valid, m_valid);
            check("pkt_data", pkt_data, m_data);
            check("frame_err", frame_err, m_ferr);
            check("overrun", overrun, m_ovr);
            check("timeout", timeout, m_to);
            if (frame_err === 1'b1) ferr_seen++;
            if (overrun === 1'b1) ovr_seen++;
            if (timeout === 1'b1) to_seen++;
            if (pkt_valid === 1'b1 && pkt_ready === 1'b1) begin
                acc_cnt++;
                acc_last = pkt_data;
            end
        end
    end

    bit rnd_rdy_en = 0;
    always @(posedge clk) begin
        if (rnd_rdy_en) begin
            #1 pkt_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends bits 0..last_bit of one frame; pulse_rdy raises pkt_ready for the CHECK cycle.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int last_bit, input bit pulse_rdy);
        logic [10:0] bits;
        ev_t         e;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i <= last_bit; i++) begin
            ps2_data = bits[i];
            idle($urandom_range(4, 10));
            ps2_clk = 1'b0;
            if (i == 10) begin
                e.stamp = cyc + 3;
                e.is_to = 0;
                e.good  = !bad_par && !bad_stop;
                e.b     = b;
                evq.push_back(e);
                last_stamp = e.stamp;
                if (pulse_rdy) begin
                    idle(3);
                    pkt_ready = 1'b1;
                    idle(1);
                    pkt_ready = 1'b0;
                end
            end
            idle($urandom_range(4, 10));
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_good(input logic [7:0] b);
        send_frame(b, 0, 0, 10, 0);
    endtask

    task automatic stray_strobe();
        ps2_data = 1'b1;
        idle(5);
        ps2_clk = 1'b0;
        idle(5);
        ps2_clk = 1'b1;
    endtask

    int f0, o0, a0, t0, r;

    initial begin
        reset_n = 1'b0;
        idle(2);
        cmp_en = 1;
        check("rst_valid", pkt_valid, 1'b0);
        check("rst_data", pkt_data, 24'h0);
        check("rst_pulses", {frame_err, overrun, timeout}, 3'b000);
        reset_n = 1'b1;
        idle(5);

        // Three good bytes, consumer always ready.
        f0 = ferr_seen; o0 = ovr_seen; a0 = acc_cnt;
        pkt_ready = 1'b1;
        send_good(8'h08); send_good(8'h05); send_good(8'hFB);
        idle(10);
        check("t1_acc_cnt", acc_cnt - a0, 1);
        check("t1_pkt", acc_last, 24'h0805FB);
        check("t1_err_pulses", (ferr_seen - f0) + (ovr_seen - o0), 0);

        // Parity error on the second byte discards the partial packet.
        f0 = ferr_seen; a0 = acc_cnt;
        send_good(8'h5A);
        send_frame(8'h3C, 1, 0, 10, 0);
        check("t2_no_valid", acc_cnt - a0, 0);
        send_good(8'h09); send_good(8'h01); send_good(8'h02);
        idle(10);
        check("t2_ferr_cnt", ferr_seen - f0, 1);
        check("t2_acc_cnt", acc_cnt - a0, 1);
        check("t2_pkt", acc_last, 24'h090102);

        // Consumer stalled: second packet is dropped.
        o0 = ovr_seen;
        pkt_ready = 1'b0;
        send_good(8'h08); send_good(8'h00); send_good(8'h00);
        send_good(8'h08); send_good(8'h11); send_good(8'h11);
        idle(10);
        check("t3_ovr_cnt", ovr_seen - o0, 1);
        check("t3_valid", pkt_valid, 1'b1);
        check("t3_data", pkt_data, 24'h080000);
        pkt_ready = 1'b1;
        idle(1);
        pkt_ready = 1'b0;
        idle(2);
        check("t3_cleared", pkt_valid, 1'b0);

        // Ready pulsed exactly in the completion cycle.
        o0 = ovr_seen;
        send_good(8'h01); send_good(8'h02); send_good(8'h03);
        idle(5);
        check("t4_first", pkt_data, 24'h010203);
        send_good(8'h04); send_good(8'h05);
        send_frame(8'h06, 0, 0, 10, 1);
        idle(5);
        check("t4_valid", pkt_valid, 1'b1);
        check("t4_data", pkt_data, 24'h040506);
        check("t4_no_ovr", ovr_seen - o0, 0);
        pkt_ready = 1'b1;
        idle(2);

        // Reset in the middle of the second byte.
        send_good(8'h11);
        send_frame(8'h22, 0, 0, 5, 0);
        reset_n = 1'b0;
        idle(1);
        reset_n = 1'b1;
        check("t6_valid", pkt_valid, 1'b0);
        check("t6_data", pkt_data, 24'h0);
        check("t6_pulses", {frame_err, overrun, timeout}, 3'b000);
        idle(5);
        a0 = acc_cnt;
        send_good(8'hA1); send_good(8'hB2); send_good(8'hC3);
        idle(10);
        check("t6_acc_cnt", acc_cnt - a0, 1);
        check("t6_pkt", acc_last, 24'hA1B2C3);

`ifdef PS2_RX_TIMEOUT_EN
        // One byte, then silence longer than the timeout.
        begin
            ev_t te;
            t0 = to_seen; a0 = acc_cnt;
            send_good(8'h08);
            te.stamp = last_stamp + TIMEOUT + 1;
            te.is_to = 1;
            te.good  = 0;
            te.b     = 8'h00;
            evq.push_back(te);
            idle(TIMEOUT + 50);
            check("t5_to_cnt", to_seen - t0, 1);
            send_good(8'h21); send_good(8'h43); send_good(8'h65);
            idle(10);
            check("t5_acc_cnt", acc_cnt - a0, 1);
            check("t5_pkt", acc_last, 24'h214365);
        end
`else
        check("no_timeout_seen", to_seen, 0);
`endif

        // Randomised traffic: bad parity/stop, stray strobes, random ready.
        reset_n = 1'b0;
        idle(1);
        reset_n = 1'b1;
        rnd_rdy_en = 1;
        for (int i = 0; i < 45; i++) begin
            r = $urandom_range(0, 11);
            if (r == 0) stray_strobe();
            else send_frame(8'($urandom), r == 1, r == 2, 10, 0);
            idle($urandom_range(0, 30));
        end
        rnd_rdy_en = 0;
        idle(2);
        pkt_ready = 1'b1;
        idle(10);
        check("model_drained", evq.size(), 0);

        cmp_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
